// File: rtl/fir_pkg.sv
// Shared widths, rounding helper and stage-valid record for the fir_ntap datapath.
package fir_pkg;

  // Accumulator width that can hold the sum of every full-width product without overflow.
  function automatic int unsigned fir_acc_w(input int unsigned dw, input int unsigned cw,
                                            input int unsigned taps);
    return dw + cw + int'($clog2(taps));
  endfunction

  // Half-LSB constant added before an arithmetic right shift (round half up).
  function automatic int unsigned fir_round_const(input int unsigned shift);
    return (shift == 0) ? 32'd0 : (32'd1 << (shift - 1));
  endfunction

  // Valid bits travelling alongside the sample: capture edge, then stage 1.
  typedef struct packed {
    logic cap;
    logic s1;
  } fir_vld_t;

endpackage

// File: rtl/fir_round_sat.sv
// Stage-2 round, shift and narrow to OW; FIR_NTAP_SAT_EN selects clamping over wrap.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned AW    = 19,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [AW-1:0] i_acc,
  output logic signed [OW-1:0] o_data_c,
  output logic                 o_sat_c
);

  // One extra bit so the rounding add cannot overflow; XW always exceeds OW.
  localparam int unsigned RW = AW + 1;
  localparam int unsigned XW = ((RW > OW) ? RW : OW) + 1;
  localparam logic signed [RW-1:0] RND = RW'(fir_round_const(SHIFT));

  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_r;
  logic signed [XW-1:0] w_rx;

  assign w_sum = RW'(i_acc) + RND;
  assign w_r   = w_sum >>> SHIFT;
  assign w_rx  = XW'(w_r);

`ifdef FIR_NTAP_SAT_EN
  logic signed [XW-1:0] w_max;
  logic signed [XW-1:0] w_min;

  assign w_max = {{(XW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  assign w_min = ~w_max;

  always_comb begin
    o_data_c = OW'(w_rx);
    o_sat_c  = 1'b0;
    if (w_rx > w_max) begin
      o_data_c = OW'(w_max);
      o_sat_c  = 1'b1;
    end else if (w_rx < w_min) begin
      o_data_c = OW'(w_min);
      o_sat_c  = 1'b1;
    end
  end
`else
  // Wrap mode keeps only the low OW bits; the discarded upper bits are folded away.
  logic w_unused_hi;

  assign w_unused_hi = ^w_rx[XW-1:OW];
  assign o_data_c    = OW'(w_rx);
  assign o_sat_c     = 1'b0;
`endif

endmodule

// File: rtl/fir_ntap.sv
// N-tap direct-form FIR: programmable coefficients, two-stage registered pipeline.
// Output clamping is enabled by defining FIR_NTAP_SAT_EN (see fir_round_sat).
module fir_ntap
  import fir_pkg::*;
#(
  parameter int unsigned TAPS     = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned CW       = 8,
  parameter int unsigned OW       = 16,
  parameter int unsigned SHIFT    = 0,
  parameter int          COEF_RST = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [DW-1:0]      in_data,
  input  logic                      clear,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_data,
  output logic                      out_valid,
  output logic signed [OW-1:0]      out_data,
  output logic                      out_sat
);

  localparam int unsigned AW = fir_acc_w(DW, CW, TAPS);
  localparam int unsigned PW = DW + CW;
  localparam int unsigned AD = $clog2(TAPS);

  // Taps, coefficients and products are flat vectors; element i sits at i*W.
  logic [TAPS*DW-1:0]   r_line;
  logic [TAPS*CW-1:0]   r_coef;
  logic [TAPS*PW-1:0]   r_prod;
  fir_vld_t             r_vld;
  logic                 r_out_valid;
  logic signed [OW-1:0] r_out_data;
  logic                 r_out_sat;

  logic signed [AW-1:0] w_acc;
  logic signed [OW-1:0] w_data;
  logic                 w_sat;

  // Coefficient bank: out-of-range addresses match no tap; clear leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef <= {TAPS{CW'(COEF_RST)}};
    end else if (coef_we) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (coef_addr == AD'(i)) begin
          r_coef[i*CW +: CW] <= coef_data;
        end
      end
    end
  end

  // Delay line and stage-1 products; products see the coefficients before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_prod <= '0;
      r_vld  <= '0;
    end else if (clear) begin
      r_line <= '0;
      r_prod <= '0;
      r_vld  <= '0;
    end else begin
      if (in_valid) begin
        r_line <= {r_line[(TAPS-1)*DW-1:0], in_data};
      end
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_prod[i*PW +: PW] <= PW'($signed(r_line[i*DW +: DW])) *
                              PW'($signed(r_coef[i*CW +: CW]));
      end
      r_vld.cap <= in_valid;
      r_vld.s1  <= r_vld.cap;
    end
  end

  always_comb begin
    w_acc = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      w_acc = w_acc + AW'($signed(r_prod[i*PW +: PW]));
    end
  end

  fir_round_sat #(
    .AW    (AW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .i_acc    (w_acc),
    .o_data_c (w_data),
    .o_sat_c  (w_sat)
  );

  // Stage 2 output register; clear drops valid/sat but keeps the last data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= r_vld.s1;
      r_out_data  <= w_data;
      r_out_sat   <= w_sat;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_ntap.sv
// Directed bench for fir_ntap: default 3-tap build plus OW=8 and SHIFT=2 variants on a shared bus.
module tb_fir_ntap;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              clear;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [7:0] coef_data;

  logic               d_ov, d_os;
  logic signed [15:0] d_od;
  logic               s_ov, s_os;
  logic signed [7:0]  s_od;
  logic               r_ov, r_os;
  logic signed [15:0] r_od;

  int n_cmp;
  int n_bad;

`ifdef FIR_NTAP_SAT_EN
  localparam int SAT8_D = 127;
  localparam int SAT8_F = 1;
  localparam int SAT16_D = 32767;
  localparam int SAT16_F = 1;
`else
  localparam int SAT8_D = 3;
  localparam int SAT8_F = 0;
  localparam int SAT16_D = -17149;
  localparam int SAT16_F = 0;
`endif

  fir_ntap #(.TAPS(3), .DW(8), .CW(8), .OW(16), .SHIFT(0), .COEF_RST(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(d_ov), .out_data(d_od), .out_sat(d_os)
  );

  fir_ntap #(.TAPS(3), .DW(8), .CW(8), .OW(8), .SHIFT(0), .COEF_RST(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(s_ov), .out_data(s_od), .out_sat(s_os)
  );

  fir_ntap #(.TAPS(3), .DW(8), .CW(8), .OW(16), .SHIFT(2), .COEF_RST(1)) u_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(r_ov), .out_data(r_od), .out_sat(r_os)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, cross the edge, and settle 1 time unit past it.
  task automatic drive(input logic v, input int d, input logic clr = 1'b0,
                       input logic we = 1'b0, input int addr = 0, input int cd = 0);
    in_valid  = v;
    in_data   = 8'(d);
    clear     = clr;
    coef_we   = we;
    coef_addr = 2'(addr);
    coef_data = 8'(cd);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic step(input string tag, input logic v, input int d, input logic ev, input int ed,
                      input logic clr = 1'b0, input logic we = 1'b0, input int addr = 0,
                      input int cd = 0);
    drive(v, d, clr, we, addr, cd);
    chk_eq({tag, ".v"}, int'(d_ov), int'(ev));
    if (ev) chk_eq({tag, ".d"}, int'(d_od), ed);
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2);
    drive(1'b0, 0, 1'b0, 1'b1, 0, c0);
    drive(1'b0, 0, 1'b0, 1'b1, 1, c1);
    drive(1'b0, 0, 1'b0, 1'b1, 2, c2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    // Reset held with a live input; nothing may come out.
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'sd5;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_eq("rst.v", int'(d_ov), 0);
      chk_eq("rst.d", int'(d_od), 0);
    end
    rst_n = 1'b1;
    step("rel0", 1'b1, 5, 1'b0, 0);
    step("rel1", 1'b0, 0, 1'b0, 0);
    step("rel2", 1'b0, 0, 1'b1, 5);
    step("rel3", 1'b0, 0, 1'b0, 0);

    // Gapped input with boxcar reset coefficients.
    drive(1'b0, 0, 1'b1);
    step("gap0", 1'b1, 10, 1'b0, 0);
    step("gap1", 1'b0, 0,  1'b0, 0);
    step("gap2", 1'b1, 20, 1'b1, 10);
    step("gap3", 1'b0, 0,  1'b0, 0);
    step("gap4", 1'b1, 30, 1'b1, 30);
    step("gap5", 1'b0, 0,  1'b0, 0);
    step("gap6", 1'b0, 0,  1'b1, 60);
    step("gap7", 1'b0, 0,  1'b0, 0);

    // Impulse response.
    set_coefs(21, 21, 21);
    drive(1'b0, 0, 1'b1);
    step("imp0", 1'b1, 1, 1'b0, 0);
    step("imp1", 1'b1, 0, 1'b0, 0);
    step("imp2", 1'b1, 0, 1'b1, 21);
    step("imp3", 1'b1, 0, 1'b1, 21);
    step("imp4", 1'b0, 0, 1'b1, 21);
    step("imp5", 1'b0, 0, 1'b1, 0);
    step("imp6", 1'b0, 0, 1'b0, 0);

    // Coefficient write racing a stage-1 product, then an out-of-range write.
    step("mc0",  1'b1, 2, 1'b0, 0);
    step("mc1",  1'b1, 0, 1'b0, 0);
    step("mc2",  1'b1, 0, 1'b1, 42, 1'b0, 1'b1, 1, 5);
    step("mc3",  1'b1, 0, 1'b1, 42, 1'b0, 1'b1, 3, 99);
    step("mc4",  1'b1, 0, 1'b1, 42);
    step("mc5",  1'b1, 1, 1'b1, 0);
    step("mc6",  1'b1, 0, 1'b1, 0);
    step("mc7",  1'b1, 0, 1'b1, 21);
    step("mc8",  1'b0, 0, 1'b1, 5);
    step("mc9",  1'b0, 0, 1'b1, 21);
    step("mc10", 1'b0, 0, 1'b0, 0);

    // Clear alongside a valid sample: sample dropped, history and pipeline flushed.
    step("cl0", 1'b1, 7, 1'b0, 0);
    step("cl1", 1'b1, 9, 1'b0, 0, 1'b1);
    chk_eq("cl1.hold", int'(d_od), 21);
    step("cl2", 1'b1, 1, 1'b0, 0);
    step("cl3", 1'b1, 0, 1'b0, 0);
    step("cl4", 1'b0, 0, 1'b1, 21);
    step("cl5", 1'b0, 0, 1'b1, 5);
    step("cl6", 1'b0, 0, 1'b0, 0);

    // Sum 48387 overflows both OW=8 and OW=16.
    set_coefs(127, 127, 127);
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 127);
    drive(1'b1, 127);
    drive(1'b1, 127);
    drive(1'b0, 0);
    drive(1'b0, 0);
    chk_eq("sat8.v",  int'(s_ov), 1);
    chk_eq("sat8.d",  int'(s_od), SAT8_D);
    chk_eq("sat8.f",  int'(s_os), SAT8_F);
    chk_eq("sat16.d", int'(d_od), SAT16_D);
    chk_eq("sat16.f", int'(d_os), SAT16_F);

    // Round half up with SHIFT=2: 6 -> 2, -6 -> -1, 5 -> 1.
    set_coefs(1, 0, 0);
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 6);
    drive(1'b1, -6);
    drive(1'b1, 5);
    chk_eq("rnd6.v", int'(r_ov), 1);
    chk_eq("rnd6.d", int'(r_od), 2);
    drive(1'b0, 0);
    chk_eq("rndm6.d", int'(r_od), -1);
    drive(1'b0, 0);
    chk_eq("rnd5.d", int'(r_od), 1);
    chk_eq("rnd5.f", int'(r_os), 0);

    // Asynchronous reset mid-stream: immediate zero outputs, coefficients back to 1.
    drive(1'b1, 50);
    drive(1'b1, 60);
    rst_n = 1'b0;
    #1;
    chk_eq("rp.v",  int'(d_ov), 0);
    chk_eq("rp.d",  int'(d_od), 0);
    chk_eq("rp.rd", int'(r_od), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rp0", 1'b1, 4, 1'b0, 0);
    step("rp1", 1'b1, 0, 1'b0, 0);
    step("rp2", 1'b0, 0, 1'b1, 4);
    step("rp3", 1'b0, 0, 1'b1, 4);
    step("rp4", 1'b0, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_ntap.md
# fir_ntap

Parametrised N-tap direct-form FIR filter with a runtime-programmable coefficient bank, valid-qualified streaming input, and a two-stage registered pipeline. Output rounding is selectable by parameter, and saturation is optional at compile time. It generalises the fixed 3-tap constant-coefficient filter. It sits in the sample datapath between a sample source and any downstream consumer that accepts valid-qualified signed samples.

## Interface
- TAPS, 8: number of taps; must be at least 2.
- DW, 8: input sample width, signed.
- CW, 8: coefficient width, signed.
- OW, 16: output width, signed.
- SHIFT, 0: arithmetic right shift applied to the sum before narrowing.
- COEF_RST, 1: reset value loaded into every coefficient (a boxcar moving sum).
- clk, in, 1: clock; all state updates on its rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- in_valid, in, 1: in_data is a sample this cycle.
- in_data, in, DW: signed input sample.
- clear, in, 1: synchronous flush of the delay line and pipeline.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, $clog2(TAPS): tap index to write.
- coef_data, in, CW: signed coefficient value.
- out_valid, out, 1: out_data holds a new result.
- out_data, out, OW: signed filtered sample.
- out_sat, out, 1: out_data was clipped this result.

## Operation
- Delay line: tap[0..TAPS-1], each DW bits. On an edge with in_valid=1: tap[0]<=in_data, and tap[i]<=tap[i-1]. With in_valid=0 the delay line holds.
- Stage 1, one edge after capture:
  - prod[i] <= tap[i]*coef[i], full width DW+CW.
  - v1 <= the in_valid value seen at the capture edge.
- Stage 2:
  - acc = sum of all prod[i], width AW = DW+CW+$clog2(TAPS); it never overflows.
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up). If SHIFT=0: r = acc.
  - r is narrowed to OW, then out_data <= narrowed r, out_valid <= v1, out_sat <= clip indication.
- Coefficient write: on an edge with coef_we=1 and coef_addr<TAPS, coef[coef_addr] <= coef_data.
  - A write with coef_addr >= TAPS is ignored.
  - A stage-1 product computed on the same edge as a write uses the old coefficient. The new value applies from the next edge.
- clear=1 at an edge:
  - tap, prod, v1, out_valid and out_sat are zeroed; out_data holds its last value.
  - Coefficients are retained.
  - clear takes priority over a simultaneous in_valid; that sample is dropped.
  - A simultaneous coef_we is still honoured.
- Reset (rst_n=0, at any time, including mid-stream): tap, prod, v1, out_valid, out_sat and out_data are set to 0, and every coef is set to COEF_RST. The first sample after release starts from an all-zero history.

## Timing
- Latency: a sample captured at edge k produces out_valid=1 after edge k+2; out_valid is high for exactly one cycle per captured sample.
- Throughput: one sample per cycle. Gaps in in_valid produce matching gaps in out_valid.
- No backpressure: the downstream consumer must accept every out_valid.
- Reset values: out_valid=0, out_data=0, out_sat=0.

## Configuration
- FIR_NTAP_SAT_EN defined:
  - When r exceeds the OW signed range, out_data clamps to 2^(OW-1)-1 or -2^(OW-1), and out_sat=1 for that result.
- FIR_NTAP_SAT_EN undefined:
  - out_data takes the low OW bits of r (two's-complement wrap).
  - out_sat is tied to 0.

## Structure
- Shared package fir_pkg:
  - function fir_acc_w(DW, CW, TAPS) returning AW.
  - function fir_round_const(SHIFT) returning the rounding constant.
  - typedef for the stage-valid record.
- Sub-module fir_round_sat: stage-2 combinational round, shift and narrow with the saturation flag. It contains the FIR_NTAP_SAT_EN conditional. The top level holds all registers and the adder.

## Test plan
Default bench: TAPS=3, DW=8, CW=8, OW=16, SHIFT=0, COEF_RST=1.
- Reset: hold rst_n=0 with in_valid=1 and in_data=5 → out_valid=0 and out_data=0 throughout. After release, the first output is 5·1.
- Impulse: write coef {21,21,21}, then inputs 1,0,0,0 on consecutive cycles → outputs 21,21,21,0, with the first output after edge k+2.
- Gapped input: inputs 10, gap, 20, gap, 30 at COEF_RST=1 → out_valid pulses produce 10, 30, 60, with matching gaps.
- Saturation (OW=8, coef {127,127,127}, three inputs of 127; sum 48387):
  - With FIR_NTAP_SAT_EN: out_data=127, out_sat=1.
  - Without it: out_data=3 (low byte of 0xBD03), out_sat=0.
- Rounding (SHIFT=2):
  - A sum of 6 yields 2.
  - A sum of -6 yields -1.
  - A sum of 5 yields 1.
- Mid-stream events:
  - coef_we to coef_addr=1 on the same edge as a stage-1 product → that product uses the old coefficient.
  - coef_addr=3 → ignored.
  - clear with in_valid on the same edge → sample dropped and history zeroed.
  - rst_n pulse mid-stream → outputs go to 0 immediately and coefficients return to COEF_RST.
